// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared data-memory constants and reader state encoding
package dmem_pkg;
   localparam int ADDR_W     = 10;
   localparam int DATA_W     = 32;
   localparam int LEN_W      = 8;
   localparam int WORD_BYTES = 4;
   localparam int MEM_BYTES  = 1024;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } rd_state_t;
endpackage

// File: rtl/stream_out_reg.sv
// rtl/stream_out_reg.sv - one-entry data/last/valid holding register for the read stream
module stream_out_reg
   import dmem_pkg::*;
#(
   parameter int DATA_W = dmem_pkg::DATA_W
) (
   input  logic              i_clk,
   input  logic              i_resetn,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_last,
   input  logic              i_ready,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic              o_last
);

   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic              r_last;

   // Loads only happen when empty or draining, so data/last never change under a stall.
   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_last  <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
         r_last  <= i_last;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_last  = r_last;

endmodule

// File: rtl/dmem_stream_reader.sv
// rtl/dmem_stream_reader.sv - block reader from the 1 KiB data memory onto a valid/ready stream
module dmem_stream_reader
   import dmem_pkg::*;
#(
   parameter int ADDR_W = dmem_pkg::ADDR_W,
   parameter int DATA_W = dmem_pkg::DATA_W,
   parameter int LEN_W  = dmem_pkg::LEN_W
) (
   input  logic              i_clk,
   input  logic              i_resetn,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic [LEN_W-1:0]  i_num_words,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err,
   output logic              o_memread,
   output logic [ADDR_W-1:0] o_address,
   input  logic [DATA_W-1:0] i_readdata,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [DATA_W-1:0] o_out_data,
   output logic              o_out_last
);

   localparam int SUM_W = ADDR_W + LEN_W + 2;
   localparam logic [SUM_W-1:0] MEM_LIMIT = SUM_W'(1) << ADDR_W;

   rd_state_t         r_state;
   rd_state_t         w_next;
   logic [ADDR_W-1:0] r_address;
   logic [LEN_W-1:0]  r_remaining;
   logic              r_err;

   logic [SUM_W-1:0]  w_end;
   logic              w_empty;
   logic              w_reject;
   logic              w_fire;
   logic              w_last_fetch;
   logic              w_out_valid;

   // End address is formed wide enough that no legal input combination can wrap.
   assign w_end        = SUM_W'(i_base_addr) + SUM_W'(i_num_words) * SUM_W'(WORD_BYTES);
   assign w_empty      = (i_num_words == '0);
   assign w_reject     = (i_base_addr[1:0] != 2'b00) || (w_end > MEM_LIMIT);
   assign w_last_fetch = (r_remaining == LEN_W'(1));

   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_next = (w_empty || w_reject) ? FIN : READ;
            end
         end
         READ: begin
            if (w_fire && w_last_fetch) begin
               w_next = DRAIN;
            end
         end
         DRAIN: begin
            if (w_out_valid && i_out_ready) begin
               w_next = FIN;
            end
         end
         FIN:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      o_busy    = (r_state != IDLE);
      o_done    = (r_state == FIN);
      o_err     = (r_state == FIN) && r_err;
      w_fire    = (r_state == READ) && (!w_out_valid || i_out_ready);
      o_memread = w_fire;
   end

   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         r_address   <= '0;
         r_remaining <= '0;
         r_err       <= 1'b0;
      end else if (r_state == IDLE) begin
         if (i_start) begin
            r_err <= !w_empty && w_reject;
            if (!w_empty && !w_reject) begin
               r_address   <= i_base_addr;
               r_remaining <= i_num_words;
            end
         end
      end else if (w_fire) begin
         r_address   <= r_address + ADDR_W'(WORD_BYTES);
         r_remaining <= r_remaining - LEN_W'(1);
      end
   end

   assign o_address   = r_address;
   assign o_out_valid = w_out_valid;

   stream_out_reg #(
      .DATA_W(DATA_W)
   ) u_out_reg (
      .i_clk    (i_clk),
      .i_resetn (i_resetn),
      .i_load   (w_fire),
      .i_data   (i_readdata),
      .i_last   (w_last_fetch),
      .i_ready  (i_out_ready),
      .o_valid  (w_out_valid),
      .o_data   (o_out_data),
      .o_last   (o_out_last)
   );

endmodule

// File: tb/tb_dmem_stream_reader.sv
// tb/tb_dmem_stream_reader.sv - self-checking bench for dmem_stream_reader
module tb_dmem_stream_reader;

   typedef struct {
      int base;
      int num;
      int mode;
      bit poke;
      bit exp_err;
      int exp_reads;
      int lat;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start;
   logic [9:0]  base;
   logic [7:0]  num;
   logic        busy, done, err, memread;
   logic [9:0]  address;
   logic [31:0] readdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_last;

   logic [7:0]  mem [0:1023];
   exp_t        sb[$];
   logic [31:0] got[$];
   vec_t        vecs[12];

   int          checks = 0;
   int          errors = 0;
   int          mr_count = 0;
   int          rmode = 0;
   int          pcnt = 0;
   bit          sb_off = 1'b0;
   bit          prev_stall = 1'b0;
   logic [31:0] prev_data;
   logic        prev_last;

   always #5 clk = ~clk;

   assign readdata = {mem[address + 10'd3], mem[address + 10'd2], mem[address + 10'd1], mem[address]};

   dmem_stream_reader dut (
      .i_clk       (clk),
      .i_resetn    (resetn),
      .i_start     (start),
      .i_base_addr (base),
      .i_num_words (num),
      .o_busy      (busy),
      .o_done      (done),
      .o_err       (err),
      .o_memread   (memread),
      .o_address   (address),
      .i_readdata  (readdata),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_out_data  (out_data),
      .o_out_last  (out_last)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      case (rmode)
         1:       out_ready = ((pcnt % 3) == 0);
         2:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b1;
      endcase
      pcnt++;
   end

   always @(negedge clk) begin
      if (!resetn || sb_off) begin
         prev_stall = 1'b0;
      end else begin
         if (memread) begin
            mr_count++;
            check("memread_outside_busy", busy, 1);
         end
         if (out_valid && !out_ready) check("memread_on_stall", memread, 0);
         if (prev_stall) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, prev_data);
            check("stall_last", out_last, prev_last);
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("extra_word_queue_size", sb.size(), 1);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("out_data", out_data, e.data);
               check("out_last", out_last, e.last);
               got.push_back(out_data);
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
      end
   end

   task automatic do_req(input vec_t v);
      int   k;
      bit   seen;
      logic err_at;
      rmode    = v.mode;
      mr_count = 0;
      if (!v.exp_err) begin
         for (int j = 0; j < v.num; j++) begin
            exp_t e;
            int   a;
            a = v.base + 4 * j;
            e.data = {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
            e.last = (j == v.num - 1);
            sb.push_back(e);
         end
      end
      @(posedge clk); #1;
      start = 1'b1;
      base  = v.base[9:0];
      num   = v.num[7:0];
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_start", busy, 1);
      seen   = 1'b0;
      err_at = 1'b0;
      k      = 0;
      while (!seen && k < 3000) begin
         @(negedge clk);
         k++;
         if (v.poke && k == 2) begin
            start = 1'b1;
            base  = 10'd8;
            num   = 8'd1;
         end
         if (v.poke && k == 3) start = 1'b0;
         if (done) begin
            seen   = 1'b1;
            err_at = err;
         end
      end
      check("done_seen", seen, 1);
      if (seen) begin
         check("err_at_done", err_at, v.exp_err);
         if (v.lat >= 0) check("done_latency", k, v.lat);
         @(negedge clk);
         check("done_one_cycle", done, 0);
         check("idle_after_done", busy, 0);
      end
      check("memread_count", mr_count, v.exp_reads);
      check("scoreboard_empty", sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      int dcount;
      for (int i = 0; i < 1024; i++) mem[i] = (i < 16) ? 8'(i) : 8'($urandom);

      vecs[0]  = '{base: 0,    num: 4,   mode: 0, poke: 0, exp_err: 0, exp_reads: 4,   lat: 6};
      vecs[1]  = '{base: 0,    num: 4,   mode: 1, poke: 0, exp_err: 0, exp_reads: 4,   lat: -1};
      vecs[2]  = '{base: 2,    num: 1,   mode: 0, poke: 0, exp_err: 1, exp_reads: 0,   lat: 1};
      vecs[3]  = '{base: 1016, num: 2,   mode: 0, poke: 0, exp_err: 0, exp_reads: 2,   lat: 4};
      vecs[4]  = '{base: 1020, num: 2,   mode: 0, poke: 0, exp_err: 1, exp_reads: 0,   lat: 1};
      vecs[5]  = '{base: 0,    num: 0,   mode: 0, poke: 0, exp_err: 0, exp_reads: 0,   lat: 1};
      vecs[6]  = '{base: 1020, num: 1,   mode: 0, poke: 0, exp_err: 0, exp_reads: 1,   lat: 3};
      vecs[7]  = '{base: 0,    num: 4,   mode: 0, poke: 1, exp_err: 0, exp_reads: 4,   lat: 6};
      vecs[8]  = '{base: 4,    num: 255, mode: 2, poke: 0, exp_err: 0, exp_reads: 255, lat: -1};
      vecs[9]  = '{base: 8,    num: 255, mode: 0, poke: 0, exp_err: 1, exp_reads: 0,   lat: 1};
      vecs[10] = '{base: 512,  num: 3,   mode: 1, poke: 0, exp_err: 0, exp_reads: 3,   lat: -1};
      vecs[11] = '{base: 100,  num: 10,  mode: 0, poke: 0, exp_err: 0, exp_reads: 10,  lat: 12};

      resetn    = 1'b0;
      start     = 1'b0;
      base      = '0;
      num       = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_memread", memread, 0);
      check("rst_address", address, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_last", out_last, 0);
      @(posedge clk); #1;
      resetn = 1'b1;

      for (int i = 0; i < 12; i++) begin
         got.delete();
         do_req(vecs[i]);
         if (i == 0) begin
            check("basic_word_count", got.size(), 4);
            if (got.size() == 4) begin
               check("basic_w0", got[0], 32'h03020100);
               check("basic_w1", got[1], 32'h07060504);
               check("basic_w2", got[2], 32'h0B0A0908);
               check("basic_w3", got[3], 32'h0F0E0D0C);
            end
         end
      end

      sb_off = 1'b1;
      rmode  = 0;
      @(posedge clk); #1;
      start = 1'b1;
      base  = 10'd0;
      num   = 8'd4;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_err", err, 0);
      check("abort_memread", memread, 0);
      check("abort_address", address, 0);
      check("abort_out_valid", out_valid, 0);
      check("abort_out_data", out_data, 0);
      check("abort_out_last", out_last, 0);
      dcount = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) dcount++;
      end
      check("abort_no_done", dcount, 0);
      sb_off = 1'b0;
      do_req(vecs[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_stream_reader.md
# dmem_stream_reader

Read-side initiator for the byte-addressed 1 KiB data memory. It fetches a block of consecutive 32-bit little-endian words starting at a word-aligned byte address and presents them, one per cycle, on a valid/ready stream to the CNN compute datapath for weight and feature loading. It drives the memory's `memread`/`address` port. The memory returns `readdata` combinationally in the same cycle. The write port (`memwrite`/`writedata`) stays with the other master.

## Interface
Parameters:
- `ADDR_W`, 10: byte address width; memory size is 2^ADDR_W bytes.
- `DATA_W`, 32: word width; 4 bytes per word.
- `LEN_W`, 8: width of the word-count request.

Ports:
- `clk` input 1: single clock; everything updates on the rising edge.
- `resetn` input 1: synchronous, active-low reset.
- `start` input 1: request pulse, sampled only in IDLE.
- `base_addr` input ADDR_W: first byte address; must be word-aligned.
- `num_words` input LEN_W: number of words to read.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: one-cycle pulse when a request finishes or is rejected.
- `err` output 1: one-cycle pulse, coincident with `done`, on a rejected request.
- `memread` output 1: memory read enable.
- `address` output ADDR_W: memory byte address; registered.
- `readdata` input DATA_W: word returned by the memory.
- `out_valid` output 1: `out_data` holds a word.
- `out_ready` input 1: consumer accepts the word.
- `out_data` output DATA_W: registered word.
- `out_last` output 1: qualifies the final word of a request.

## Operation
States are IDLE, READ, DRAIN and FIN.

IDLE:
- `start` is only acted on here; `base_addr` and `num_words` are captured together with it.
- `num_words`==0 → FIN with `err`=0. No memory access is made.
- `base_addr[1:0]`≠0, or `base_addr` + 4·`num_words` > 2^ADDR_W → FIN with `err`=1. No memory access is made.
- The overrun sum is computed at ADDR_W+LEN_W+2 bits. No truncation or wrap is allowed.
- Otherwise → READ, with `address`=`base_addr` and the remaining count = `num_words`.

READ:
- `memread` = (`out_valid`==0 || `out_ready`==1). This output is combinational from state and the output register.
- While `memread` is high, `readdata` is loaded into `out_data` at the edge and `out_valid` is set.
- On the same edge, `address` advances by 4 and the remaining count decrements.
- `out_last` is set together with the word fetched when remaining==1; that fetch moves the FSM → DRAIN.

DRAIN:
- No memory access.
- The FSM waits for `out_valid` && `out_ready` on the last word, then → FIN.

FIN:
- `done`=1 for exactly one cycle.
- `err` is as decided in IDLE.
- The FSM returns → IDLE.

Output register rules:
- `out_valid` clears on a handshake unless it is refilled on the same edge.
- `out_data` and `out_last` are held stable while `out_valid` && !`out_ready`.

Boundary conditions:
- `start` in any state other than IDLE is ignored.
- `memread` is never high outside READ.
- The last legal word is at byte 2^ADDR_W−4. An access to 1020 with `num_words`=1 is legal.
- `out_ready` low for N cycles stalls the reads for N cycles; no word is skipped or duplicated.
- Reset mid-request aborts immediately: no `done` pulse, and any pending word is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `memread`=0, `address`=0, `out_valid`=0, `out_data`=0, `out_last`=0.
- `start` sampled at edge E0: `busy` goes high at E0+. The first `memread` is asserted in the cycle after E0. The first `out_valid` is asserted after E0+2.
- Throughput with `out_ready` held high: one word per cycle.
- Accepted request of N words with no backpressure: `done` pulses in cycle E0+N+2.
- Rejected request: `done`/`err` pulse in the cycle after E0, then IDLE.
- A new `start` is accepted in the cycle `done` is low again, i.e. in IDLE.

## Structure
- Shared package `dmem_pkg` holds:
  - `ADDR_W`, `DATA_W` and `WORD_BYTES`=4;
  - `MEM_BYTES`=1024;
  - the state enum `rd_state_t` (IDLE/READ/DRAIN/FIN).
- The data memory's writer master imports the same constants.
- One sub-module: `stream_out_reg`, the one-entry data/last/valid holding register with its load/drain rule. The FSM, address/count logic and request checks stay in the top module.

## Test plan
- Memory bytes 0..15 = 0x00..0x0F; `start`, base=0, N=4, `out_ready`=1 → `out_data` 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C on consecutive cycles. `out_last` is high on the 4th word only; `done` pulses once, `err`=0.
- Same request with `out_ready` toggling 1,0,0,1,…:
  - the same 4 words arrive in order with no duplicates;
  - `out_data` is stable while stalled;
  - `memread` is low on stall cycles.
- base=2, N=1 → `done`=`err`=1 one cycle later; `memread` never asserts.
- base=1016, N=2 → accepted and reads 1016 and 1020. base=1020, N=2 → rejected with `err`=1.
- N=0 → `done`=1, `err`=0, no `memread`.
- `start` pulsed again mid-request is ignored.
- `resetn`=0 in the second READ cycle → next cycle all outputs equal their reset values, no `done`. A fresh request afterwards completes normally.
